// File: rtl/frame_deser.sv
// frame_deser: serial frame receiver.
//
// Receives frames of the form: start bit (0), DATA_W data bits LSB first,
// optional parity bit, stop bit (1). Each good word is presented on a
// valid/ready output slot. Parity, framing and overrun faults are reported as
// single-cycle pulses and the offending word is dropped.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sin        in   serial line, idle high, sampled once per clk
//   out_data   out  received word, first bit received lands in bit 0
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   consumer accepts the word when out_valid && out_ready
//   par_err    out  pulse: parity mismatch, word dropped
//   frm_err    out  pulse: stop bit sampled low, word dropped
//   ovr_err    out  pulse: good word dropped because the slot was occupied

module frame_deser #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              frm_err,
    output logic              ovr_err
);

    // Counter only has to reach DATA_W-1.
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_par_err;
    logic              r_frm_err;
    logic              r_ovr_err;

    logic [DATA_W-1:0] w_shift_next;
    logic              w_par_bad;
    logic              w_slot_free;

    // New bit enters at the top so that after DATA_W shifts the first bit
    // received sits in bit 0. Written this way so DATA_W=1 needs no slice.
    always_comb begin
        w_shift_next             = r_shift >> 1;
        w_shift_next[DATA_W-1]   = sin;
    end

    // r_par already includes the received parity bit when this is evaluated.
    assign w_par_bad   = (PARITY_EN != 0) && (r_par != 1'(ODD_PARITY));
    // Slot is usable if empty or being drained on this very edge.
    assign w_slot_free = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;

            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (!sin) begin
                        r_cnt   <= '0;
                        r_par   <= 1'b0;
                        r_state <= StData;
                    end
                end

                StData: begin
                    r_shift <= w_shift_next;
                    r_par   <= r_par ^ sin;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= (PARITY_EN != 0) ? StParity : StStop;
                    end
                end

                StParity: begin
                    r_par   <= r_par ^ sin;
                    r_state <= StStop;
                end

                StStop: begin
                    if (sin) begin
                        r_state <= StIdle;
                        if (w_par_bad) begin
                            r_par_err <= 1'b1;
                        end else if (w_slot_free) begin
                            // Overrides the drain above: valid stays high.
                            r_out_data  <= r_shift;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_ovr_err <= 1'b1;
                        end
                    end else begin
                        r_frm_err <= 1'b1;
                        r_state   <= StBreak;
                    end
                end

                StBreak: begin
                    // A line held low must not be mistaken for a start bit.
                    if (sin) begin
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign par_err   = r_par_err;
    assign frm_err   = r_frm_err;
    assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_frame_deser.sv
// tb_frame_deser: randomized self-checking bench for frame_deser.
//
// A frame-level reference model tracks the output slot (held word and
// valid flag) and decides the outcome of each frame from its data, parity
// and stop bit. Every cycle the DUT outputs are compared with the model.

module tb_frame_deser;

    localparam int unsigned DW = 12;
    localparam int unsigned PE = 1;
    localparam int unsigned OP = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sin;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          par_err;
    logic          frm_err;
    logic          ovr_err;

    int n_chk = 0;
    int n_err = 0;

    // Model state.
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;

    // Expected events for the next edge.
    bit            exp_par  = 1'b0;
    bit            exp_frm  = 1'b0;
    bit            exp_ovr  = 1'b0;
    bit            exp_load = 1'b0;
    logic [DW-1:0] exp_word = '0;

    frame_deser #(
        .DATA_W     (DW),
        .PARITY_EN  (PE),
        .ODD_PARITY (OP)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .par_err   (par_err),
        .frm_err   (frm_err),
        .ovr_err   (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: ready low, 1: ready high, 2: random
    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom % 2);
    endfunction

    // Drive one line bit for one clock and check all outputs just after the edge.
    task automatic tick(input logic s, input logic rdy);
        sin       = s;
        out_ready = rdy;
        @(posedge clk);
        if (exp_load) begin
            m_valid = 1'b1;
            m_data  = exp_word;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) check_eq("out_data", 32'(out_data), 32'(m_data));
        check_eq("par_err", 32'(par_err), 32'(exp_par));
        check_eq("frm_err", 32'(frm_err), 32'(exp_frm));
        check_eq("ovr_err", 32'(ovr_err), 32'(exp_ovr));
        exp_par  = 1'b0;
        exp_frm  = 1'b0;
        exp_ovr  = 1'b0;
        exp_load = 1'b0;
    endtask

    // Send a complete frame. rmode sets out_ready during the frame, smode on
    // the stop-bit cycle. The bench always runs with parity enabled.
    task automatic send_frame(input logic [DW-1:0] d, input bit flip, input bit stop,
                              input int rmode, input int smode);
        logic p;
        logic r;
        tick(1'b0, pick(rmode));
        for (int k = 0; k < int'(DW); k++) tick(d[k], pick(rmode));
        p = 1'($countones(d)) ^ 1'(OP);
        if (flip) p = ~p;
        tick(p, pick(rmode));
        r = pick(smode);
        if (!stop) begin
            exp_frm = 1'b1;
        end else if (flip) begin
            exp_par = 1'b1;
        end else if (!m_valid || r) begin
            exp_load = 1'b1;
            exp_word = d;
        end else begin
            exp_ovr = 1'b1;
        end
        tick(stop, r);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(out_data), 32'd0);
        check_eq({tag, "_par"}, 32'(par_err), 32'd0);
        check_eq({tag, "_frm"}, 32'(frm_err), 32'd0);
        check_eq({tag, "_ovr"}, 32'(ovr_err), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n     = 1'b0;
        sin       = 1'b1;
        out_ready = 1'b0;
        #2;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        repeat (3) tick(1'b1, 1'b1);

        // Good word, then parity error.
        send_frame(12'hA5C, 1'b0, 1'b1, 1, 1);
        tick(1'b1, 1'b1);
        send_frame(12'hA5C, 1'b1, 1'b1, 1, 1);
        tick(1'b1, 1'b1);

        // Framing error, long break, recovery.
        send_frame(12'h3C3, 1'b0, 1'b0, 1, 1);
        repeat (20) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        send_frame(12'h001, 1'b0, 1'b1, 1, 1);
        tick(1'b1, 1'b1);

        // Overrun with consumer stalled, then drain.
        send_frame(12'h123, 1'b0, 1'b1, 0, 0);
        send_frame(12'h456, 1'b0, 1'b1, 0, 0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        // Drain and reload on the same edge.
        send_frame(12'h0F0, 1'b0, 1'b1, 0, 0);
        tick(1'b1, 1'b0);
        send_frame(12'hF0F, 1'b0, 1'b1, 0, 1);
        tick(1'b1, 1'b1);

        // Reset in the middle of a frame, with a word held.
        send_frame(12'h5A5, 1'b0, 1'b1, 0, 0);
        d = 12'hC3A;
        tick(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) tick(d[k], 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        m_valid = 1'b0;
        sin     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick(1'b1, 1'b1);
        send_frame(12'h7E1, 1'b0, 1'b1, 1, 1);
        tick(1'b1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            bit flip;
            bit stop;
            d    = DW'($urandom);
            flip = ($urandom_range(0, 5) == 0);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, flip, stop, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if (!stop) begin
                repeat ($urandom_range(0, 5)) tick(1'b0, pick(2));
                tick(1'b1, pick(2));
            end else begin
                repeat ($urandom_range(0, 2)) tick(1'b1, pick(2));
            end
        end
        repeat (3) tick(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
